spi_cmd_ctrl: RTL and testbench

Command sequencer for the `spi_byte` shifter. It runs in the `sys_clk` domain and consumes the one-cycle `valid` strobe and received byte from `spi_byte`. It decodes a small read/write command protocol from the MCU and drives a single-outstanding request/acknowledge port toward the bus arbiter. It also supplies the byte `spi_byte` shifts out next, so the MCU can read and write the PET's 17-bit address space over SPI.

---
 rtl/spi_cmd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - SPI command decoder driving a single-outstanding bus request port
module spi_cmd_ctrl (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        spi_cs_n,
  input  logic [7:0]  rx,
  input  logic        valid,
  output logic [7:0]  tx,
  output logic [16:0] addr,
  output logic [7:0]  wr_data,
  output logic        we,
  output logic        pending,
  input  logic        done,
  input  logic [7:0]  rd_data_in,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_BUSY,
    S_DRAIN
  } state_t;

  localparam logic [2:0] OP_WRITE_AT   = 3'b100;
  localparam logic [2:0] OP_READ_AT    = 3'b011;
  localparam logic [2:0] OP_WRITE_NEXT = 3'b000;
  localparam logic [2:0] OP_READ_NEXT  = 3'b001;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        pending_q, pending_d;
  logic        we_q, we_d;
  logic        overrun_q, overrun_d;
  logic        cs_meta_q, cs_meta_d;
  logic        cs_sync_q, cs_sync_d;

  logic abort;
  logic done_hit;
  logic byte_ok;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    pending_d = pending_q;
    we_d      = we_q;
    overrun_d = overrun_q;
    cs_meta_d = spi_cs_n;
    cs_sync_d = cs_meta_q;

    abort    = cs_sync_q;
    done_hit = done && pending_q;
    // A byte arriving alongside done is a readback byte, not an overrun.
    byte_ok  = valid && !pending_q && !abort;

    if (valid && pending_q && !done) begin
      overrun_d = 1'b1;
    end

    // Completion side effects apply even if the frame was aborted meanwhile.
    if (done_hit) begin
      pending_d = 1'b0;
      if (!we_q) begin
        rd_data_d = rd_data_in;
      end
      addr_d = addr_q + 17'd1;
      if (state_q == S_BUSY) begin
        state_d = S_DRAIN;
      end
    end

    if (byte_ok) begin
      case (state_q)
        S_CMD: begin
          op_d = rx[7:5];
          case (rx[7:5])
            OP_WRITE_AT, OP_READ_AT: begin
              addr_d[16] = rx[0];
              state_d    = S_ADDR_HI;
            end
            OP_WRITE_NEXT: state_d = S_DATA;
            OP_READ_NEXT: begin
              pending_d = 1'b1;
              we_d      = 1'b0;
              state_d   = S_BUSY;
            end
            default: state_d = S_DRAIN;
          endcase
        end
        S_ADDR_HI: begin
          addr_d[15:8] = rx;
          state_d      = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_d[7:0] = rx;
          if (op_q == OP_READ_AT) begin
            pending_d = 1'b1;
            we_d      = 1'b0;
            state_d   = S_BUSY;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          wr_data_d = rx;
          pending_d = 1'b1;
          we_d      = 1'b1;
          state_d   = S_BUSY;
        end
        default: ;
      endcase
    end

    if (abort) begin
      state_d = S_CMD;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= S_CMD;
      op_q      <= 3'd0;
      addr_q    <= 17'd0;
      wr_data_q <= 8'd0;
      rd_data_q <= 8'd0;
      pending_q <= 1'b0;
      we_q      <= 1'b0;
      overrun_q <= 1'b0;
      cs_meta_q <= 1'b1;
      cs_sync_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      pending_q <= pending_d;
      we_q      <= we_d;
      overrun_q <= overrun_d;
      cs_meta_q <= cs_meta_d;
      cs_sync_q <= cs_sync_d;
    end
  end

  assign tx      = rd_data_q;
  assign addr    = addr_q;
  assign wr_data = wr_data_q;
  assign we      = we_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - directed self-checking bench for spi_cmd_ctrl
module tb_spi_cmd_ctrl;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic [7:0]  rx = 8'd0;
  logic        valid = 1'b0;
  logic [7:0]  tx;
  logic [16:0] addr;
  logic [7:0]  wr_data;
  logic        we;
  logic        pending;
  logic        done = 1'b0;
  logic [7:0]  rd_data_in = 8'd0;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  spi_cmd_ctrl dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .spi_cs_n   (spi_cs_n),
    .rx         (rx),
    .valid      (valid),
    .tx         (tx),
    .addr       (addr),
    .wr_data    (wr_data),
    .we         (we),
    .pending    (pending),
    .done       (done),
    .rd_data_in (rd_data_in),
    .overrun    (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = b;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [7:0] d);
    done = 1'b1;
    rd_data_in = d;
    tick();
    done = 1'b0;
  endtask

  task automatic end_frame();
    spi_cs_n = 1'b1;
    idle(4);
    spi_cs_n = 1'b0;
    idle(3);
  endtask

  initial begin
    idle(3);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_tx", 32'(tx), 32'h0);
    check("rst_we", 32'(we), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    reset = 1'b0;
    spi_cs_n = 1'b0;
    idle(3);

    // WRITE_AT 0x18000 <= 0xA5
    send_byte(8'h81); idle(1);
    send_byte(8'h80); idle(1);
    send_byte(8'h00);
    check("wa_no_req_yet", 32'(pending), 32'h0);
    idle(1);
    send_byte(8'hA5);
    check("wa_pending", 32'(pending), 32'h1);
    check("wa_we", 32'(we), 32'h1);
    check("wa_addr", 32'(addr), 32'h18000);
    check("wa_wr_data", 32'(wr_data), 32'hA5);
    pulse_done(8'hFF);
    check("wa_done_pending", 32'(pending), 32'h0);
    check("wa_done_addr", 32'(addr), 32'h18001);
    check("wa_tx_unchanged", 32'(tx), 32'h0);
    end_frame();

    // READ_AT 0x01234, done after 5 cycles
    send_byte(8'h60); send_byte(8'h12); send_byte(8'h34);
    check("ra_pending", 32'(pending), 32'h1);
    check("ra_we", 32'(we), 32'h0);
    check("ra_addr", 32'(addr), 32'h01234);
    idle(4);
    pulse_done(8'h3C);
    check("ra_tx", 32'(tx), 32'h3C);
    check("ra_addr_next", 32'(addr), 32'h01235);
    check("ra_pending_low", 32'(pending), 32'h0);
    end_frame();

    // Position at 0x1FFFF, then READ_NEXT twice across frames
    send_byte(8'h61); send_byte(8'hFF); send_byte(8'hFE);
    check("pos_addr", 32'(addr), 32'h1FFFE);
    pulse_done(8'h10);
    check("pos_addr_next", 32'(addr), 32'h1FFFF);
    end_frame();
    send_byte(8'h20);
    check("rn1_pending", 32'(pending), 32'h1);
    check("rn1_addr", 32'(addr), 32'h1FFFF);
    check("rn1_we", 32'(we), 32'h0);
    pulse_done(8'h5A);
    check("rn1_tx", 32'(tx), 32'h5A);
    check("rn1_wrap", 32'(addr), 32'h00000);
    end_frame();
    send_byte(8'h20);
    check("rn2_pending", 32'(pending), 32'h1);
    check("rn2_addr", 32'(addr), 32'h00000);
    pulse_done(8'h6B);
    check("rn2_tx", 32'(tx), 32'h6B);
    check("rn2_addr_next", 32'(addr), 32'h00001);
    end_frame();

    // Abort after addr_hi; next frame decodes a fresh command
    send_byte(8'h81); send_byte(8'h22);
    spi_cs_n = 1'b1;
    idle(4);
    check("abort_no_req", 32'(pending), 32'h0);
    spi_cs_n = 1'b0;
    idle(3);
    send_byte(8'h00);
    check("abort_fresh_no_req", 32'(pending), 32'h0);
    send_byte(8'h77);
    check("wn_pending", 32'(pending), 32'h1);
    check("wn_we", 32'(we), 32'h1);
    check("wn_addr", 32'(addr), 32'h12201);
    check("wn_wr_data", 32'(wr_data), 32'h77);
    pulse_done(8'h00);
    check("wn_addr_next", 32'(addr), 32'h12202);
    end_frame();

    // valid coincident with done: no overrun
    send_byte(8'h20);
    rx = 8'hEE; valid = 1'b1; done = 1'b1; rd_data_in = 8'h44;
    tick();
    valid = 1'b0; done = 1'b0;
    check("sim_overrun", 32'(overrun), 32'h0);
    check("sim_pending", 32'(pending), 32'h0);
    check("sim_tx", 32'(tx), 32'h44);
    check("sim_addr", 32'(addr), 32'h12203);
    end_frame();

    // Overrun while the arbiter stalls
    send_byte(8'h20);
    send_byte(8'h99);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_still_pending", 32'(pending), 32'h1);
    idle(100);
    check("ovr_sticky", 32'(overrun), 32'h1);
    pulse_done(8'hC3);
    check("ovr_req_done", 32'(pending), 32'h0);
    check("ovr_tx", 32'(tx), 32'hC3);
    check("ovr_addr", 32'(addr), 32'h12204);
    check("ovr_sticky2", 32'(overrun), 32'h1);
    end_frame();

    // Reset during S_BUSY
    send_byte(8'h00); send_byte(8'h55);
    check("rb_pending", 32'(pending), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rb_pending_clr", 32'(pending), 32'h0);
    check("rb_addr", 32'(addr), 32'h0);
    check("rb_wr_data", 32'(wr_data), 32'h0);
    check("rb_we", 32'(we), 32'h0);
    check("rb_overrun", 32'(overrun), 32'h0);
    check("rb_tx", 32'(tx), 32'h0);
    pulse_done(8'hAB);
    check("rb_done_ign_addr", 32'(addr), 32'h0);
    check("rb_done_ign_tx", 32'(tx), 32'h0);
    check("rb_done_ign_pend", 32'(pending), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
